plab4_net_router_ter_out_demux_tp: RTL and testbench

Per-domain ejection buffer that sits directly downstream of the timing-protected router's terminal output port. It accepts the time-multiplexed terminal output stream (valid/ready/message, labelled by the current `domain`), steers each message into a private FIFO for domain 0 or domain 1, and presents two independent per-domain ejection interfaces to the terminals. Ready toward the router depends only on the state of the FIFO for the currently active domain, so one domain's backpressure never becomes visible in the other domain's time slot.

---
 rtl/plab4_net_router_ter_out_demux_tp.sv | 120 ++++++++++++
 tb/tb_plab4_net_router_ter_out_demux_tp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_ter_out_demux_tp.sv
// Terminal-output demux for the timing-protected router: steers the
// time-multiplexed ejection stream into one private FIFO per security
// domain and exposes two independent ejection interfaces.
module plab4_net_router_ter_out_demux_tp #(
   parameter int p_payload_nbits = 32,
   parameter int p_opaque_nbits  = 3,
   parameter int p_srcdest_nbits = 3,
   parameter int p_router_id     = 0,
   parameter int p_num_msgs      = 4,
   parameter int c_net_msg_nbits = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       domain,

   input  logic                       in_val,
   output logic                       in_rdy,
   input  logic [c_net_msg_nbits-1:0] in_msg,

   output logic                       out_val_d0,
   input  logic                       out_rdy_d0,
   output logic [c_net_msg_nbits-1:0] out_msg_d0,

   output logic                       out_val_d1,
   input  logic                       out_rdy_d1,
   output logic [c_net_msg_nbits-1:0] out_msg_d1,

   output logic [15:0]                num_recv_d0,
   output logic [15:0]                num_recv_d1,
   output logic                       dest_err_d0,
   output logic                       dest_err_d1
);

   localparam int c_ptr_nbits = $clog2(p_num_msgs);
   localparam int c_cnt_nbits = c_ptr_nbits + 1;
   localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_msgs);
   localparam logic [p_srcdest_nbits-1:0] c_my_id = p_srcdest_nbits'(p_router_id);

   // Message layout is {dest, src, opaque, payload}; dest occupies the MSBs.
   logic [p_srcdest_nbits-1:0] in_dest;
   logic                       in_dest_bad;

   logic [c_net_msg_nbits-1:0] q0_mem [p_num_msgs];
   logic [c_net_msg_nbits-1:0] q1_mem [p_num_msgs];

   logic [c_ptr_nbits-1:0] q0_head, q0_tail;
   logic [c_ptr_nbits-1:0] q1_head, q1_tail;
   logic [c_cnt_nbits-1:0] q0_count, q1_count;

   logic enq0, enq1, deq0, deq1;

   // Ready depends only on the active domain's registered occupancy so one
   // domain's backpressure is never visible in the other domain's slot.
   always_comb begin
      in_rdy      = domain ? (q1_count != c_full) : (q0_count != c_full);
      in_dest     = in_msg[c_net_msg_nbits-1 -: p_srcdest_nbits];
      in_dest_bad = (in_dest != c_my_id);
      enq0        = in_val && in_rdy && !domain;
      enq1        = in_val && in_rdy &&  domain;
      out_val_d0  = (q0_count != '0);
      out_val_d1  = (q1_count != '0);
      deq0        = out_val_d0 && out_rdy_d0;
      deq1        = out_val_d1 && out_rdy_d1;
      out_msg_d0  = q0_mem[q0_head];
      out_msg_d1  = q1_mem[q1_head];
   end

   // Storage write for both queues; no reset needed since pointers gate reads.
   always_ff @(posedge clk) begin
      if (enq0) q0_mem[q0_tail] <= in_msg;
      if (enq1) q1_mem[q1_tail] <= in_msg;
   end

   // Domain-0 queue pointers, occupancy, receive counter and dest-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         q0_head     <= '0;
         q0_tail     <= '0;
         q0_count    <= '0;
         num_recv_d0 <= '0;
         dest_err_d0 <= 1'b0;
      end else begin
         if (enq0) begin
            q0_tail     <= q0_tail + c_ptr_nbits'(1);
            num_recv_d0 <= num_recv_d0 + 16'd1;
            if (in_dest_bad) dest_err_d0 <= 1'b1;
         end
         if (deq0) q0_head <= q0_head + c_ptr_nbits'(1);
         case ({enq0, deq0})
            2'b10:   q0_count <= q0_count + c_cnt_nbits'(1);
            2'b01:   q0_count <= q0_count - c_cnt_nbits'(1);
            default: q0_count <= q0_count;
         endcase
      end
   end

   // Domain-1 queue pointers, occupancy, receive counter and dest-error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         q1_head     <= '0;
         q1_tail     <= '0;
         q1_count    <= '0;
         num_recv_d1 <= '0;
         dest_err_d1 <= 1'b0;
      end else begin
         if (enq1) begin
            q1_tail     <= q1_tail + c_ptr_nbits'(1);
            num_recv_d1 <= num_recv_d1 + 16'd1;
            if (in_dest_bad) dest_err_d1 <= 1'b1;
         end
         if (deq1) q1_head <= q1_head + c_ptr_nbits'(1);
         case ({enq1, deq1})
            2'b10:   q1_count <= q1_count + c_cnt_nbits'(1);
            2'b01:   q1_count <= q1_count - c_cnt_nbits'(1);
            default: q1_count <= q1_count;
         endcase
      end
   end

endmodule

// File: tb/tb_plab4_net_router_ter_out_demux_tp.sv
// Bench for the per-domain terminal output demux: queue-based reference
// model checked every cycle, plus directed checks from the test plan.
module tb_plab4_net_router_ter_out_demux_tp;

   localparam int ID    = 0;
   localparam int DEPTH = 4;
   localparam int W     = 41;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          domain = 1'b0;
   logic          in_val = 1'b0;
   logic          in_rdy;
   logic [W-1:0]  in_msg = '0;
   logic          out_val_d0, out_val_d1;
   logic          out_rdy_d0 = 1'b0, out_rdy_d1 = 1'b0;
   logic [W-1:0]  out_msg_d0, out_msg_d1;
   logic [15:0]   num_recv_d0, num_recv_d1;
   logic          dest_err_d0, dest_err_d1;

   plab4_net_router_ter_out_demux_tp #(
      .p_payload_nbits (32),
      .p_opaque_nbits  (3),
      .p_srcdest_nbits (3),
      .p_router_id     (ID),
      .p_num_msgs      (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .domain      (domain),
      .in_val      (in_val),
      .in_rdy      (in_rdy),
      .in_msg      (in_msg),
      .out_val_d0  (out_val_d0),
      .out_rdy_d0  (out_rdy_d0),
      .out_msg_d0  (out_msg_d0),
      .out_val_d1  (out_val_d1),
      .out_rdy_d1  (out_rdy_d1),
      .out_msg_d1  (out_msg_d1),
      .num_recv_d0 (num_recv_d0),
      .num_recv_d1 (num_recv_d1),
      .dest_err_d0 (dest_err_d0),
      .dest_err_d1 (dest_err_d1)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [W-1:0] mq0[$], mq1[$];
   logic [15:0]  mrecv0, mrecv1;
   logic         merr0, merr1;
   logic [31:0]  got0[$], got1[$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [W-1:0] mk(input int dest, input int src, input int opq,
                                       input logic [31:0] pay);
      return {3'(dest), 3'(src), 3'(opq), pay};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq0.delete(); mq1.delete();
      mrecv0 = '0; mrecv1 = '0;
      merr0 = 1'b0; merr1 = 1'b0;
   endtask

   // One clock: compare DUT against the model at negedge, then advance the
   // model at posedge. Returns whether the input message was accepted.
   task automatic cycle(output bit acc);
      bit rdy, d0, d1;
      @(negedge clk);
      rdy = domain ? (mq1.size() != DEPTH) : (mq0.size() != DEPTH);
      chk("in_rdy", in_rdy, rdy);
      chk("out_val_d0", out_val_d0, mq0.size() != 0);
      chk("out_val_d1", out_val_d1, mq1.size() != 0);
      if (mq0.size() != 0) chk("out_msg_d0", out_msg_d0, mq0[0]);
      if (mq1.size() != 0) chk("out_msg_d1", out_msg_d1, mq1[0]);
      chk("num_recv_d0", num_recv_d0, mrecv0);
      chk("num_recv_d1", num_recv_d1, mrecv1);
      chk("dest_err_d0", dest_err_d0, merr0);
      chk("dest_err_d1", dest_err_d1, merr1);
      d0  = (mq0.size() != 0) && out_rdy_d0;
      d1  = (mq1.size() != 0) && out_rdy_d1;
      if (d0) got0.push_back(out_msg_d0[31:0]);
      if (d1) got1.push_back(out_msg_d1[31:0]);
      acc = in_val && rdy && !reset;
      @(posedge clk);
      if (reset) begin
         model_clear();
         acc = 1'b0;
      end else begin
         if (d0) void'(mq0.pop_front());
         if (d1) void'(mq1.pop_front());
         if (acc) begin
            if (!domain) begin
               mq0.push_back(in_msg); mrecv0++;
               if (in_msg[W-1 -: 3] != 3'(ID)) merr0 = 1'b1;
            end else begin
               mq1.push_back(in_msg); mrecv1++;
               if (in_msg[W-1 -: 3] != 3'(ID)) merr1 = 1'b1;
            end
         end
      end
      #1;
   endtask

   bit acc;
   int s0, s1, guard;

   initial begin
      // ---- reset ----
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_in_rdy", in_rdy, 1'b1);
      chk("rst_out_val_d0", out_val_d0, 1'b0);
      chk("rst_out_val_d1", out_val_d1, 1'b0);
      chk("rst_num_recv_d0", num_recv_d0, 16'd0);
      chk("rst_num_recv_d1", num_recv_d1, 16'd0);
      chk("rst_dest_err_d0", dest_err_d0, 1'b0);
      chk("rst_dest_err_d1", dest_err_d1, 1'b0);

      // ---- basic routing ----
      domain = 1'b0; in_val = 1'b1; in_msg = mk(ID, 1, 2, 32'hA5);
      cycle(acc);
      in_val = 1'b0;
      #1;
      chk("basic_val_d0", out_val_d0, 1'b1);
      chk("basic_pay_d0", out_msg_d0[31:0], 32'hA5);
      chk("basic_val_d1", out_val_d1, 1'b0);
      chk("basic_recv_d0", num_recv_d0, 16'd1);
      out_rdy_d0 = 1'b1;
      cycle(acc);
      got0.delete();

      // ---- fill and backpressure isolation ----
      out_rdy_d0 = 1'b0; domain = 1'b0; in_val = 1'b1;
      for (int p = 1; p <= 4; p++) begin
         in_msg = mk(ID, 0, 0, 32'(p));
         cycle(acc);
         chk("fill_acc", acc, 1'b1);
      end
      in_msg = mk(ID, 0, 0, 32'd5);
      #1 chk("full_rdy_d0slot", in_rdy, 1'b0);
      domain = 1'b1; in_msg = mk(ID, 0, 0, 32'h77);
      #1 chk("full_rdy_d1slot", in_rdy, 1'b1);
      cycle(acc);
      in_val = 1'b0; out_rdy_d1 = 1'b1;
      #1;
      chk("iso_val_d1", out_val_d1, 1'b1);
      chk("iso_pay_d1", out_msg_d1[31:0], 32'h77);
      cycle(acc);
      out_rdy_d1 = 1'b0;

      // ---- full plus dequeue in the same cycle ----
      domain = 1'b0; in_val = 1'b1; in_msg = mk(ID, 0, 0, 32'd5); out_rdy_d0 = 1'b1;
      #1 chk("fulldeq_rdy", in_rdy, 1'b0);
      cycle(acc);
      chk("freed_rdy", in_rdy, 1'b1);
      cycle(acc);
      chk("freed_acc", acc, 1'b1);
      in_val = 1'b0;
      repeat (6) cycle(acc);
      chk("order_cnt_d0", got0.size(), 5);
      for (int i = 0; i < 5 && i < got0.size(); i++)
         chk("order_d0", got0[i], 32'(i + 1));
      got0.delete(); got1.delete();

      // ---- alternating domain, random drain ----
      s0 = 0; s1 = 0;
      for (int c = 0; c < 400 && (s0 < 20 || s1 < 20); c++) begin
         domain = c[0];
         in_val = domain ? (s1 < 20) : (s0 < 20);
         in_msg = mk(ID, int'($urandom_range(7)), int'($urandom_range(7)),
                     domain ? 32'h1000 + 32'(s1) : 32'(s0));
         out_rdy_d0 = $urandom_range(1);
         out_rdy_d1 = $urandom_range(1);
         cycle(acc);
         if (acc) begin
            if (domain) s1++; else s0++;
         end
      end
      in_val = 1'b0; out_rdy_d0 = 1'b1; out_rdy_d1 = 1'b1;
      repeat (10) cycle(acc);
      chk("alt_sent_d0", s0, 20);
      chk("alt_sent_d1", s1, 20);
      chk("alt_cnt_d0", got0.size(), 20);
      chk("alt_cnt_d1", got1.size(), 20);
      for (int i = 0; i < 20 && i < got0.size(); i++) chk("alt_order_d0", got0[i], 32'(i));
      for (int i = 0; i < 20 && i < got1.size(); i++) chk("alt_order_d1", got1[i], 32'h1000 + 32'(i));
      got0.delete(); got1.delete();

      // ---- dest error ----
      out_rdy_d0 = 1'b0; out_rdy_d1 = 1'b0;
      domain = 1'b1; in_val = 1'b1; in_msg = mk(ID + 1, 0, 0, 32'hDE);
      cycle(acc);
      in_val = 1'b0;
      #1;
      chk("derr_d1", dest_err_d1, 1'b1);
      chk("derr_d0", dest_err_d0, 1'b0);
      out_rdy_d1 = 1'b1;
      cycle(acc);
      cycle(acc);
      chk("derr_sticky_d1", dest_err_d1, 1'b1);
      chk("derr_deliv_cnt", got1.size(), 1);
      if (got1.size() != 0) chk("derr_deliv_pay", got1[0], 32'hDE);
      got1.delete();

      // ---- counter wrap ----
      domain = 1'b0; in_val = 1'b1; out_rdy_d0 = 1'b1; out_rdy_d1 = 1'b0;
      guard = 0;
      while (mrecv0 != 16'hFFFF && guard < 70000) begin
         in_msg = mk(ID, 0, 0, 32'(guard));
         cycle(acc);
         guard++;
      end
      got0.delete();
      in_val = 1'b0;
      #1 chk("wrap_pre", num_recv_d0, 16'hFFFF);
      in_val = 1'b1;
      cycle(acc);
      chk("wrap_post", num_recv_d0, 16'h0000);

      // ---- reset mid-operation ----
      out_rdy_d0 = 1'b0; out_rdy_d1 = 1'b0;
      domain = 1'b0; in_msg = mk(ID, 0, 0, 32'h11);
      cycle(acc);
      domain = 1'b1; in_msg = mk(ID, 0, 0, 32'h22);
      cycle(acc);
      chk("pre_rst_val_d0", out_val_d0, 1'b1);
      chk("pre_rst_val_d1", out_val_d1, 1'b1);
      reset = 1'b1; in_msg = mk(ID, 0, 0, 32'h33);
      cycle(acc);
      reset = 1'b0; in_val = 1'b0;
      #1;
      chk("mid_rst_val_d0", out_val_d0, 1'b0);
      chk("mid_rst_val_d1", out_val_d1, 1'b0);
      chk("mid_rst_rdy_dom1", in_rdy, 1'b1);
      chk("mid_rst_recv_d1", num_recv_d1, 16'd0);
      chk("mid_rst_err_d1", dest_err_d1, 1'b0);
      domain = 1'b0;
      #1 chk("mid_rst_rdy_dom0", in_rdy, 1'b1);
      repeat (2) cycle(acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
